// File: rtl/al422_frame_writer.sv
// AL422 write-side controller: each sof-framed stream is written from FIFO address 0.
// Optional mid-frame idle abort is enabled by defining WRITER_TIMEOUT_EN.
module al422_frame_writer #(
    parameter int PIXEL_COUNT     = 64,
    parameter int BYTES_PER_PIXEL = 3,
    parameter int WRST_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic [7:0] s_data,
    input  logic       s_sof,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] al422_data_out,
    output logic       al422_wck_out,
    output logic       al422_nwe_out,
    output logic       al422_nwrst_out,
    output logic       frame_done,
    output logic       frame_error
);

    localparam int FRAME_BYTES = PIXEL_COUNT * BYTES_PER_PIXEL;
    localparam int CW = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int WW = $clog2(2 * WRST_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(FRAME_BYTES - 1);
    localparam logic [WW-1:0] WRST_LAST = WW'(2 * WRST_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRST,
        S_WRITE
    } state_e;

    state_e state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic hfull_q, hfull_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic pa_q, pa_d;
    logic pb_q, pb_d;
    logic armed_q, armed_d;
    logic [7:0] data_q, data_d;
    logic wck_q, wck_d;
    logic nwe_q, nwe_d;
    logic nwrst_q, nwrst_d;
    logic done_q, done_d;
    logic err_q, err_d;
    logic last;
    logic acc;

`ifdef WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] idle_q, idle_d;
`else
    logic unused_tmo;
    assign unused_tmo = (TIMEOUT_CYCLES != 0);
`endif

    assign last = (cnt_q == CNT_LAST);
    assign acc  = s_valid & s_ready;

    // The final phase B refuses data so the next byte must be a fresh sof.
    always_comb begin
        unique case (state_q)
            S_IDLE:  s_ready = armed_q;
            S_WRITE: s_ready = (!hfull_q || pb_q) && !(pb_q && last);
            default: s_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        hfull_d = hfull_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        pa_d    = pa_q;
        pb_d    = pb_q;
        armed_d = 1'b1;
        data_d  = data_q;
        wck_d   = wck_q;
        nwe_d   = nwe_q;
        nwrst_d = nwrst_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
`ifdef WRITER_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (acc && s_sof) begin
                    hold_d  = s_data;
                    hfull_d = 1'b1;
                    state_d = S_WRST;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    wck_d   = 1'b0;
                    nwe_d   = 1'b1;
                    nwrst_d = 1'b0;
                end
            end
            S_WRST: begin
                wcnt_d = wcnt_q + 1'b1;
                wck_d  = ~wck_q;
`ifdef WRITER_TIMEOUT_EN
                idle_d = '0;
`endif
                if (wcnt_q == WRST_LAST) begin
                    state_d = S_WRITE;
                    nwrst_d = 1'b1;
                    wck_d   = 1'b0;
                    pa_d    = 1'b1;
                    nwe_d   = 1'b0;
                    data_d  = hold_q;
                end
            end
            S_WRITE: begin
                if (pa_q) begin
                    pa_d  = 1'b0;
                    pb_d  = 1'b1;
                    wck_d = 1'b1;
                end else begin
                    if (pb_q) hfull_d = 1'b0;
                    if (acc) begin
                        hold_d  = s_data;
                        hfull_d = 1'b1;
                    end
                    pb_d = 1'b0;
                    if (pb_q && last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        wck_d   = 1'b0;
                        nwe_d   = 1'b1;
                    end else if (acc && s_sof) begin
                        err_d   = 1'b1;
                        state_d = S_WRST;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                        wck_d   = 1'b0;
                        nwe_d   = 1'b1;
                        nwrst_d = 1'b0;
                    end else begin
                        if (pb_q) cnt_d = cnt_q + 1'b1;
                        wck_d = 1'b0;
                        if (hfull_d) begin
                            pa_d   = 1'b1;
                            nwe_d  = 1'b0;
                            data_d = hold_d;
                        end else begin
                            nwe_d = 1'b1;
                        end
`ifdef WRITER_TIMEOUT_EN
                        if (acc || pb_q) begin
                            idle_d = '0;
                        end else if (!hfull_q) begin
                            if (idle_q == TMO_LAST) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                                nwe_d   = 1'b1;
                                idle_d  = '0;
                            end else begin
                                idle_d = idle_q + 1'b1;
                            end
                        end
`endif
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q <= S_IDLE;
            hold_q  <= '0;
            hfull_q <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pa_q    <= 1'b0;
            pb_q    <= 1'b0;
            armed_q <= 1'b0;
            data_q  <= '0;
            wck_q   <= 1'b0;
            nwe_q   <= 1'b1;
            nwrst_q <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WRITER_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            hfull_q <= hfull_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pa_q    <= pa_d;
            pb_q    <= pb_d;
            armed_q <= armed_d;
            data_q  <= data_d;
            wck_q   <= wck_d;
            nwe_q   <= nwe_d;
            nwrst_q <= nwrst_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef WRITER_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end

    assign al422_data_out  = data_q;
    assign al422_wck_out   = wck_q;
    assign al422_nwe_out   = nwe_q;
    assign al422_nwrst_out = nwrst_q;
    assign frame_done      = done_q;
    assign frame_error     = err_q;

endmodule

// File: tb/tb_al422_frame_writer.sv
// Bench for al422_frame_writer: scoreboard of accepted bytes vs bytes seen on WCK rises.
// Define WRITER_TIMEOUT_EN on both files to exercise the idle abort.
module tb_al422_frame_writer;

    localparam int FB = 192;

    logic       in_clk = 1'b0;
    logic       in_nrst = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_sof = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [7:0] al422_data_out;
    logic       al422_wck_out;
    logic       al422_nwe_out;
    logic       al422_nwrst_out;
    logic       frame_done;
    logic       frame_error;

    al422_frame_writer #(
        .PIXEL_COUNT(64),
        .BYTES_PER_PIXEL(3),
        .WRST_CYCLES(4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .in_clk(in_clk),
        .in_nrst(in_nrst),
        .s_data(s_data),
        .s_sof(s_sof),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .al422_data_out(al422_data_out),
        .al422_wck_out(al422_wck_out),
        .al422_nwe_out(al422_nwe_out),
        .al422_nwrst_out(al422_nwrst_out),
        .frame_done(frame_done),
        .frame_error(frame_error)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int failures = 0;

    // Output monitor, samples 2ns after each rising edge.
    int cyc = 0;
    int obs_n = 0;
    logic [7:0] obs_mem [0:4095];
    int wrst_low = 0;
    int wrst_rise = 0;
    int nwe_low = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int err_cnt = 0;
    int err_cyc = 0;
    int both_cnt = 0;
    int pair_bad = 0;
    logic prev_wck = 1'b0;
    logic prev_pa = 1'b0;
    logic [7:0] prev_data = 8'h00;

    always @(posedge in_clk) begin
        logic pa_now, pb_now;
        #2;
        cyc = cyc + 1;
        if (al422_wck_out && !prev_wck) begin
            if (!al422_nwrst_out) begin
                wrst_rise = wrst_rise + 1;
            end else if (obs_n < 4096) begin
                obs_mem[obs_n] = al422_data_out;
                obs_n = obs_n + 1;
            end
        end
        if (!al422_nwrst_out) wrst_low = wrst_low + 1;
        if (!al422_nwe_out) nwe_low = nwe_low + 1;
        if (frame_done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (frame_error) begin
            err_cnt = err_cnt + 1;
            err_cyc = cyc;
        end
        if (frame_done && frame_error) both_cnt = both_cnt + 1;
        pa_now = !al422_wck_out && !al422_nwe_out;
        pb_now = al422_wck_out && !al422_nwe_out;
        if (prev_pa && !(pb_now && al422_data_out == prev_data))
            pair_bad = pair_bad + 1;
        if (pb_now && !prev_pa) pair_bad = pair_bad + 1;
        prev_pa = pa_now;
        prev_wck = al422_wck_out;
        prev_data = al422_data_out;
    end

    logic [7:0] exp_q [$];
    int rd = 0;
    int first_acc = 0;
    int last_acc = 0;

    task automatic step(input logic v, input logic sof,
                        input logic [7:0] d, output logic acc);
        @(negedge in_clk);
        s_valid = v;
        s_sof = sof;
        s_data = d;
        acc = v && s_ready;
    endtask

    task automatic idle(input int n);
        logic acc;
        repeat (n) step(1'b0, 1'b0, 8'h00, acc);
    endtask

    task automatic send_bytes(input int first, input int n, input int gap,
                              input logic sof0, input logic push,
                              output logic ok);
        logic acc;
        int waited;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            waited = 0;
            do begin
                step(1'b1, sof0 && (i == 0), 8'(first + i), acc);
                waited++;
            end while (!acc && waited < 100);
            if (!acc) begin
                ok = 1'b0;
                break;
            end
            last_acc = cyc;
            if (i == 0) first_acc = cyc;
            if (push) exp_q.push_back(8'(first + i));
            for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 8'h00, acc);
        end
        step(1'b0, 1'b0, 8'h00, acc);
    endtask

    task automatic test_reset();
        logic [13:0] v;
        logic [13:0] ev;
        ev = {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        in_nrst = 1'b0;
        repeat (3) @(negedge in_clk);
        v = {s_ready, al422_data_out, al422_wck_out, al422_nwe_out,
             al422_nwrst_out, frame_done, frame_error};
        checks++;
        if (v !== ev) begin
            failures++;
            $display("FAIL reset_outputs got %b exp %b", v, ev);
        end
        in_nrst = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_release got %b exp 0", s_ready);
        end
        @(posedge in_clk);
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_clock got %b exp 1", s_ready);
        end
    endtask

    task automatic test_idle_drop();
        int o0, w0, r0, n0, nacc;
        logic acc;
        o0 = obs_n; w0 = wrst_low; r0 = wrst_rise; n0 = nwe_low;
        nacc = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 8'(8'h30 + i), acc);
            if (acc) nacc++;
        end
        idle(4);
        checks++;
        if (nacc !== 10) begin
            failures++;
            $display("FAIL idle_accept got %0d exp 10", nacc);
        end
        checks++;
        if ((obs_n - o0) + (wrst_rise - r0) !== 0) begin
            failures++;
            $display("FAIL idle_wck_rises got %0d exp 0",
                     (obs_n - o0) + (wrst_rise - r0));
        end
        checks++;
        if ((wrst_low - w0) + (nwe_low - n0) !== 0) begin
            failures++;
            $display("FAIL idle_strobes got %0d exp 0",
                     (wrst_low - w0) + (nwe_low - n0));
        end
    endtask

    task automatic test_frame();
        int o0, w0, r0, n0, d0, e0, p0;
        logic ok;
        logic [7:0] e;
        o0 = obs_n; w0 = wrst_low; r0 = wrst_rise; n0 = nwe_low;
        d0 = done_cnt; e0 = err_cnt; p0 = pair_bad;
        send_bytes(0, FB, 0, 1'b1, 1'b1, ok);
        idle(20);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame_accept got stall exp all bytes taken");
        end
        checks++;
        if (wrst_low - w0 !== 8) begin
            failures++;
            $display("FAIL frame_wrst_low got %0d exp 8", wrst_low - w0);
        end
        checks++;
        if (wrst_rise - r0 !== 4) begin
            failures++;
            $display("FAIL frame_wrst_rises got %0d exp 4", wrst_rise - r0);
        end
        checks++;
        if (obs_n - o0 !== FB) begin
            failures++;
            $display("FAIL frame_writes got %0d exp %0d", obs_n - o0, FB);
        end
        checks++;
        if (nwe_low - n0 !== 2 * FB) begin
            failures++;
            $display("FAIL frame_we_low got %0d exp %0d", nwe_low - n0, 2 * FB);
        end
        checks++;
        if (done_cnt - d0 !== 1 || done_cyc - first_acc !== 393) begin
            failures++;
            $display("FAIL frame_done got n=%0d lat=%0d exp n=1 lat=393",
                     done_cnt - d0, done_cyc - first_acc);
        end
        checks++;
        if (err_cnt - e0 !== 0 || pair_bad - p0 !== 0) begin
            failures++;
            $display("FAIL frame_clean got err=%0d pair=%0d exp 0 0",
                     err_cnt - e0, pair_bad - p0);
        end
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_mem[rd] !== e) begin
                failures++;
                $display("FAIL frame_data[%0d] got %h exp %h", rd, obs_mem[rd], e);
            end
            rd++;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL frame_unwritten got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_throttled();
        int o0, w0, n0, d0, p0;
        logic ok;
        logic [7:0] e;
        o0 = obs_n; w0 = wrst_low; n0 = nwe_low; d0 = done_cnt; p0 = pair_bad;
        send_bytes(0, FB, 2, 1'b1, 1'b1, ok);
        idle(20);
        checks++;
        if (!ok || obs_n - o0 !== FB) begin
            failures++;
            $display("FAIL thr_writes got %0d ok=%b exp %0d", obs_n - o0, ok, FB);
        end
        checks++;
        if (nwe_low - n0 !== 2 * FB || pair_bad - p0 !== 0) begin
            failures++;
            $display("FAIL thr_we got low=%0d pair=%0d exp %0d 0",
                     nwe_low - n0, pair_bad - p0, 2 * FB);
        end
        checks++;
        if (done_cnt - d0 !== 1 || wrst_low - w0 !== 8) begin
            failures++;
            $display("FAIL thr_done got n=%0d wrst=%0d exp 1 8",
                     done_cnt - d0, wrst_low - w0);
        end
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_mem[rd] !== e) begin
                failures++;
                $display("FAIL thr_data[%0d] got %h exp %h", rd, obs_mem[rd], e);
            end
            rd++;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL thr_unwritten got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_abort();
        int o0, w0, d0, e0, b0, abort_acc;
        logic ok1, ok2;
        logic [7:0] e;
        o0 = obs_n; w0 = wrst_low; d0 = done_cnt; e0 = err_cnt; b0 = both_cnt;
        send_bytes(0, 100, 0, 1'b1, 1'b1, ok1);
        send_bytes(8'hA0, FB, 0, 1'b1, 1'b1, ok2);
        abort_acc = first_acc;
        idle(20);
        checks++;
        if (!ok1 || !ok2 || obs_n - o0 !== 100 + FB) begin
            failures++;
            $display("FAIL abort_writes got %0d exp %0d", obs_n - o0, 100 + FB);
        end
        checks++;
        if (err_cnt - e0 !== 1 || err_cyc - abort_acc !== 1) begin
            failures++;
            $display("FAIL abort_error got n=%0d lat=%0d exp 1 1",
                     err_cnt - e0, err_cyc - abort_acc);
        end
        checks++;
        if (wrst_low - w0 !== 16) begin
            failures++;
            $display("FAIL abort_wrst got %0d exp 16", wrst_low - w0);
        end
        checks++;
        if (done_cnt - d0 !== 1 || done_cyc - abort_acc !== 393) begin
            failures++;
            $display("FAIL abort_done got n=%0d lat=%0d exp 1 393",
                     done_cnt - d0, done_cyc - abort_acc);
        end
        checks++;
        if (both_cnt - b0 !== 0) begin
            failures++;
            $display("FAIL abort_overlap got %0d exp 0", both_cnt - b0);
        end
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_mem[rd] !== e) begin
                failures++;
                $display("FAIL abort_data[%0d] got %h exp %h", rd, obs_mem[rd], e);
            end
            rd++;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL abort_unwritten got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_stall();
        int o0, d0, e0, stall_acc;
        logic ok1, ok2;
        logic [7:0] e;
        o0 = obs_n; d0 = done_cnt; e0 = err_cnt;
        send_bytes(0, 11, 0, 1'b1, 1'b1, ok1);
        stall_acc = last_acc;
        idle(40);
`ifdef WRITER_TIMEOUT_EN
        send_bytes(11, 5, 0, 1'b0, 1'b0, ok2);
        idle(10);
        checks++;
        if (err_cnt - e0 !== 1 || err_cyc - stall_acc !== 19) begin
            failures++;
            $display("FAIL stall_timeout got n=%0d lat=%0d exp 1 19",
                     err_cnt - e0, err_cyc - stall_acc);
        end
        checks++;
        if (!ok1 || !ok2 || obs_n - o0 !== 11 || done_cnt - d0 !== 0) begin
            failures++;
            $display("FAIL stall_dropped got w=%0d d=%0d exp 11 0",
                     obs_n - o0, done_cnt - d0);
        end
`else
        send_bytes(11, FB - 11, 0, 1'b0, 1'b1, ok2);
        idle(20);
        checks++;
        if (err_cnt - e0 !== 0) begin
            failures++;
            $display("FAIL stall_error got %0d exp 0 at %0d", err_cnt - e0, stall_acc);
        end
        checks++;
        if (!ok1 || !ok2 || obs_n - o0 !== FB || done_cnt - d0 !== 1) begin
            failures++;
            $display("FAIL stall_resume got w=%0d d=%0d exp %0d 1",
                     obs_n - o0, done_cnt - d0, FB);
        end
`endif
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_mem[rd] !== e) begin
                failures++;
                $display("FAIL stall_data[%0d] got %h exp %h", rd, obs_mem[rd], e);
            end
            rd++;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL stall_unwritten got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid();
        int o0, w0, d0;
        logic ok;
        logic [13:0] v;
        logic [13:0] ev;
        logic [7:0] e;
        ev = {1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        o0 = obs_n;
        send_bytes(0, 50, 0, 1'b1, 1'b1, ok);
        @(negedge in_clk);
        in_nrst = 1'b0;
        #1;
        v = {s_ready, al422_data_out, al422_wck_out, al422_nwe_out,
             al422_nwrst_out, frame_done, frame_error};
        checks++;
        if (v !== ev) begin
            failures++;
            $display("FAIL midreset_outputs got %b exp %b", v, ev);
        end
        repeat (2) @(negedge in_clk);
        in_nrst = 1'b1;
        idle(3);
        checks++;
        if (!ok || obs_n - o0 !== 50) begin
            failures++;
            $display("FAIL midreset_writes got %0d exp 50", obs_n - o0);
        end
        o0 = obs_n; w0 = wrst_low; d0 = done_cnt;
        send_bytes(8'h40, FB, 0, 1'b1, 1'b1, ok);
        idle(20);
        checks++;
        if (!ok || obs_n - o0 !== FB || wrst_low - w0 !== 8) begin
            failures++;
            $display("FAIL midreset_restart got w=%0d wrst=%0d exp %0d 8",
                     obs_n - o0, wrst_low - w0, FB);
        end
        checks++;
        if (done_cnt - d0 !== 1 || done_cyc - first_acc !== 393) begin
            failures++;
            $display("FAIL midreset_done got n=%0d lat=%0d exp 1 393",
                     done_cnt - d0, done_cyc - first_acc);
        end
        while (exp_q.size() > 0 && rd < obs_n) begin
            e = exp_q.pop_front();
            checks++;
            if (obs_mem[rd] !== e) begin
                failures++;
                $display("FAIL midreset_data[%0d] got %h exp %h", rd, obs_mem[rd], e);
            end
            rd++;
        end
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL midreset_unwritten got %0d exp 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_idle_drop();
        test_frame();
        test_throttled();
        test_abort();
        test_stall();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog");
    end

endmodule
